// File: rtl/rc_pkg.sv
// Shared definitions for the route-computation stage: flit types,
// one-hot output directions, channel indices and the per-channel state type.
package rc_pkg;

    localparam logic [1:0] FLIT_HEAD   = 2'b10;
    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_TAIL   = 2'b01;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    localparam logic [4:0] DIR_E = 5'b00001;
    localparam logic [4:0] DIR_W = 5'b00010;
    localparam logic [4:0] DIR_S = 5'b00100;
    localparam logic [4:0] DIR_N = 5'b01000;
    localparam logic [4:0] DIR_L = 5'b10000;

    // Channel indices; the first four double as pressure slot indices.
    localparam int CH_E = 0;
    localparam int CH_W = 1;
    localparam int CH_S = 2;
    localparam int CH_N = 3;
    localparam int CH_L = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } chan_state_t;

endpackage

// File: rtl/rc_channel.sv
// One route-computation channel: one-flit pipeline register, wormhole lock
// FSM and the minimal (optionally pressure-adaptive) route function.
// Optional feature macro: RC_ADAPTIVE_EN (adaptive dx/dy choice).
//
// state     | meaning
// ----------|----------------------------------------------------------
// ST_IDLE   | no packet in flight; head/single flits compute a route
// ST_LOCKED | head seen; body/tail flits reuse r_lock_dir until the tail
module rc_channel
    import rc_pkg::*;
#(
    parameter int X_COORD  = 0,
    parameter int Y_COORD  = 1,
    parameter int MESH_X   = 4,
    parameter int MESH_Y   = 4,
    parameter int CW       = 2,
    parameter int DATASIZE = 40,
    parameter int WIDTH    = 3
) (
    input  logic                    rc_clk,
    input  logic                    rst_n,
    input  logic [DATASIZE-1:0]     in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*(WIDTH+1)-1:0]  pressure_in,
    output logic [DATASIZE-1:0]     data_out,
    output logic [4:0]              direction_out,
    output logic                    out_valid,
    input  logic                    rc_ready,
    output logic                    rc_err
);

    localparam int PW = WIDTH + 1;

    chan_state_t         r_state;
    logic [4:0]          r_lock_dir;
    logic [DATASIZE-1:0] r_data;
    logic [4:0]          r_dir;
    logic                r_valid;
    logic                r_err;

    logic [1:0]          w_type;
    logic [CW-1:0]       w_dest_x;
    logic [CW-1:0]       w_dest_y;
    logic [4:0]          w_x_dir;
    logic [4:0]          w_y_dir;
    logic [4:0]          w_route_dir;
    logic                w_route_err;
    logic                w_accept;

    assign w_type   = in_data[DATASIZE-1 -: 2];
    assign w_dest_x = in_data[2*CW-1:CW];
    assign w_dest_y = in_data[CW-1:0];
    assign in_ready = !r_valid || rc_ready;
    assign w_accept = in_valid && in_ready;

`ifdef RC_ADAPTIVE_EN
    logic [PW-1:0] w_p_x;
    logic [PW-1:0] w_p_y;
    assign w_p_x = (w_x_dir == DIR_E) ? pressure_in[CH_E*PW +: PW] : pressure_in[CH_W*PW +: PW];
    assign w_p_y = (w_y_dir == DIR_N) ? pressure_in[CH_N*PW +: PW] : pressure_in[CH_S*PW +: PW];
`else
    logic w_unused_pressure;
    assign w_unused_pressure = ^pressure_in;
`endif

    // Route for a head/single flit; off-mesh destinations go local and flag an error.
    always_comb begin
        w_x_dir     = 5'b0;
        w_y_dir     = 5'b0;
        w_route_dir = DIR_L;
        w_route_err = 1'b0;
        if (int'(w_dest_x) >= MESH_X || int'(w_dest_y) >= MESH_Y) begin
            w_route_err = 1'b1;
        end else begin
            if (int'(w_dest_x) > X_COORD)      w_x_dir = DIR_E;
            else if (int'(w_dest_x) < X_COORD) w_x_dir = DIR_W;
            if (int'(w_dest_y) > Y_COORD)      w_y_dir = DIR_N;
            else if (int'(w_dest_y) < Y_COORD) w_y_dir = DIR_S;
            if (w_x_dir != 5'b0 && w_y_dir != 5'b0) begin
`ifdef RC_ADAPTIVE_EN
                w_route_dir = (w_p_y < w_p_x) ? w_y_dir : w_x_dir;
`else
                w_route_dir = w_x_dir;
`endif
            end else if (w_x_dir != 5'b0) begin
                w_route_dir = w_x_dir;
            end else if (w_y_dir != 5'b0) begin
                w_route_dir = w_y_dir;
            end
        end
    end

    // Pipeline register plus wormhole lock FSM with registered outputs.
    always_ff @(posedge rc_clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_lock_dir <= 5'b0;
            r_data     <= '0;
            r_dir      <= 5'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_accept) begin
                r_valid <= 1'b1;
                r_data  <= in_data;
                case (r_state)
                    ST_IDLE: begin
                        case (w_type)
                            FLIT_HEAD: begin
                                r_dir      <= w_route_dir;
                                r_err      <= w_route_err;
                                r_lock_dir <= w_route_dir;
                                r_state    <= ST_LOCKED;
                            end
                            FLIT_SINGLE: begin
                                r_dir <= w_route_dir;
                                r_err <= w_route_err;
                            end
                            default: begin
                                r_dir <= DIR_L;
                                r_err <= 1'b1;
                            end
                        endcase
                    end
                    ST_LOCKED: begin
                        case (w_type)
                            FLIT_BODY: begin
                                r_dir <= r_lock_dir;
                            end
                            FLIT_TAIL: begin
                                r_dir   <= r_lock_dir;
                                r_state <= ST_IDLE;
                            end
                            FLIT_HEAD: begin
                                r_dir      <= w_route_dir;
                                r_err      <= 1'b1;
                                r_lock_dir <= w_route_dir;
                            end
                            default: begin
                                r_dir   <= w_route_dir;
                                r_err   <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        endcase
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (rc_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out      = r_data;
    assign direction_out = r_dir;
    assign out_valid     = r_valid;
    assign rc_err        = r_err;

endmodule

// File: rtl/rc_mesh_adaptive.sv
// Route-computation stage for one mesh router node: NUM_CH independent
// rc_channel instances; this level only slices the flat buses.
// Optional feature macro: RC_ADAPTIVE_EN (pressure-driven adaptive routing).
module rc_mesh_adaptive
    import rc_pkg::*;
#(
    parameter int X_COORD  = 0,
    parameter int Y_COORD  = 1,
    parameter int MESH_X   = 4,
    parameter int MESH_Y   = 4,
    parameter int CW       = 2,
    parameter int DATASIZE = 40,
    parameter int WIDTH    = 3,
    parameter int NUM_CH   = 5
) (
    input  logic                       rc_clk,
    input  logic                       rst_n,
    input  logic [NUM_CH*DATASIZE-1:0] in_data,
    input  logic [NUM_CH-1:0]          in_valid,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic [4*(WIDTH+1)-1:0]     pressure_in,
    output logic [NUM_CH*DATASIZE-1:0] data_out,
    output logic [NUM_CH*5-1:0]        direction_out,
    output logic [NUM_CH-1:0]          out_valid,
    input  logic [NUM_CH-1:0]          rc_ready,
    output logic [NUM_CH-1:0]          rc_err
);

    // One channel per input port, all sharing the neighbour pressure bus.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        rc_channel #(
            .X_COORD  (X_COORD),
            .Y_COORD  (Y_COORD),
            .MESH_X   (MESH_X),
            .MESH_Y   (MESH_Y),
            .CW       (CW),
            .DATASIZE (DATASIZE),
            .WIDTH    (WIDTH)
        ) u_ch (
            .rc_clk        (rc_clk),
            .rst_n         (rst_n),
            .in_data       (in_data[c*DATASIZE +: DATASIZE]),
            .in_valid      (in_valid[c]),
            .in_ready      (in_ready[c]),
            .pressure_in   (pressure_in),
            .data_out      (data_out[c*DATASIZE +: DATASIZE]),
            .direction_out (direction_out[c*5 +: 5]),
            .out_valid     (out_valid[c]),
            .rc_ready      (rc_ready[c]),
            .rc_err        (rc_err[c])
        );
    end

endmodule

// File: tb/tb_rc_mesh_adaptive.sv
// Self-checking bench for rc_mesh_adaptive (node (0,1), 4x4 mesh) plus a
// second instance with MESH_X=3 for the off-mesh destination case.
module tb_rc_mesh_adaptive;
    import rc_pkg::*;

    localparam int NCH = 5;
    localparam int DS  = 40;
    localparam int PW  = 4;
    localparam int XC  = 0;
    localparam int YC  = 1;

    logic               rc_clk = 1'b0;
    logic               rst_n  = 1'b0;
    logic [NCH*DS-1:0]  in_data = '0;
    logic [NCH-1:0]     in_valid = '0;
    logic [NCH-1:0]     rc_ready = '1;
    logic [4*PW-1:0]    pressure_in = '0;

    logic [NCH-1:0]     in_ready, out_valid, rc_err;
    logic [NCH*DS-1:0]  data_out;
    logic [NCH*5-1:0]   direction_out;

    logic [NCH-1:0]     in_ready_3, out_valid_3, rc_err_3;
    logic [NCH*DS-1:0]  data_out_3;
    logic [NCH*5-1:0]   direction_out_3;

    int tests = 0;
    int fails = 0;

    // Reference model state per channel
    logic          m_valid  [NCH];
    logic [DS-1:0] m_data   [NCH];
    logic [4:0]    m_dir    [NCH];
    logic          m_err    [NCH];
    logic          m_locked [NCH];
    logic [4:0]    m_lock   [NCH];

    always #5 rc_clk = ~rc_clk;

    rc_mesh_adaptive #(.X_COORD(XC), .Y_COORD(YC), .MESH_X(4), .MESH_Y(4),
                       .CW(2), .DATASIZE(DS), .WIDTH(3), .NUM_CH(NCH)) dut (
        .rc_clk(rc_clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .pressure_in(pressure_in), .data_out(data_out),
        .direction_out(direction_out), .out_valid(out_valid), .rc_ready(rc_ready),
        .rc_err(rc_err));

    rc_mesh_adaptive #(.X_COORD(XC), .Y_COORD(YC), .MESH_X(3), .MESH_Y(4),
                       .CW(2), .DATASIZE(DS), .WIDTH(3), .NUM_CH(NCH)) dut3 (
        .rc_clk(rc_clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_3), .pressure_in(pressure_in), .data_out(data_out_3),
        .direction_out(direction_out_3), .out_valid(out_valid_3), .rc_ready(rc_ready),
        .rc_err(rc_err_3));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Minimal route from signed coordinate offsets; pressures only break dx/dy ties.
    function automatic logic [4:0] ref_route(input int mx, input int dx, input int dy,
                                             input logic [15:0] p, output logic err);
        int hor, ver;
        logic [4:0] xd, yd;
        err = 1'b0;
        if (dx >= mx || dy >= 4) begin
            err = 1'b1;
            return DIR_L;
        end
        hor = dx - XC;
        ver = dy - YC;
        xd  = (hor > 0) ? DIR_E : DIR_W;
        yd  = (ver > 0) ? DIR_N : DIR_S;
        if (hor == 0 && ver == 0) return DIR_L;
        if (ver == 0) return xd;
        if (hor == 0) return yd;
`ifdef RC_ADAPTIVE_EN
        begin
            int px, py;
            px = (hor > 0) ? int'(p[3:0])   : int'(p[7:4]);
            py = (ver > 0) ? int'(p[15:12]) : int'(p[11:8]);
            if (py < px) return yd;
        end
`endif
        return xd;
    endfunction

    function automatic logic [DS-1:0] mk_flit(input logic [1:0] t, input int dx, input int dy);
        logic [DS-1:0] f;
        f = {8'($urandom), $urandom};
        f[DS-1 -: 2] = t;
        f[3:2] = 2'(dx);
        f[1:0] = 2'(dy);
        return f;
    endfunction

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            logic [DS-1:0] f;
            logic [1:0]    t;
            logic [4:0]    rd;
            logic          re;
            if (!rst_n) begin
                m_valid[c] = 0; m_data[c] = '0; m_dir[c] = '0;
                m_err[c] = 0; m_locked[c] = 0; m_lock[c] = '0;
            end else begin
                f = in_data[c*DS +: DS];
                t = f[DS-1 -: 2];
                m_err[c] = 0;
                if (in_valid[c] && (!m_valid[c] || rc_ready[c])) begin
                    m_valid[c] = 1;
                    m_data[c]  = f;
                    rd = ref_route(4, int'(f[3:2]), int'(f[1:0]), pressure_in, re);
                    if (t == FLIT_HEAD || t == FLIT_SINGLE) begin
                        m_dir[c]    = rd;
                        m_err[c]    = re || m_locked[c];
                        m_locked[c] = (t == FLIT_HEAD);
                        m_lock[c]   = rd;
                    end else if (m_locked[c]) begin
                        m_dir[c] = m_lock[c];
                        if (t == FLIT_TAIL) m_locked[c] = 0;
                    end else begin
                        m_dir[c] = DIR_L;
                        m_err[c] = 1;
                    end
                end else if (rc_ready[c]) begin
                    m_valid[c] = 0;
                end
            end
        end
    endtask

    // One clock: check in_ready before the edge, outputs 1 time unit after it.
    task automatic step();
        #1;
        for (int c = 0; c < NCH; c++)
            check($sformatf("in_ready[%0d]", c), 64'(in_ready[c]), 64'(!m_valid[c] || rc_ready[c]));
        @(posedge rc_clk);
        model_edge();
        #1;
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("out_valid[%0d]", c), 64'(out_valid[c]), 64'(m_valid[c]));
            check($sformatf("data_out[%0d]", c), 64'(data_out[c*DS +: DS]), 64'(m_data[c]));
            check($sformatf("dir[%0d]", c), 64'(direction_out[c*5 +: 5]), 64'(m_dir[c]));
            check($sformatf("rc_err[%0d]", c), 64'(rc_err[c]), 64'(m_err[c]));
        end
    endtask

    task automatic send1(input int ch, input logic [DS-1:0] f);
        in_valid = '0;
        in_valid[ch] = 1'b1;
        in_data[ch*DS +: DS] = f;
        step();
        in_valid = '0;
    endtask

    logic [DS-1:0] fa, fb, fc;

    initial begin
        // Reset with all valids high
        rst_n = 0; in_valid = '1; rc_ready = '1;
        in_data = {8'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        repeat (2) @(posedge rc_clk);
        model_edge();
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_dir", 64'(direction_out), 64'(0));
        check("rst_err", 64'(rc_err), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(5'b11111));
        in_valid = '0; rst_n = 1;
        step();

        // Local channel singles
        send1(CH_L, mk_flit(FLIT_SINGLE, 0, 1));
        check("l_local_valid", 64'(out_valid[4]), 64'(1));
        check("l_local_dir", 64'(direction_out[4*5 +: 5]), 64'(5'b10000));
        send1(CH_L, mk_flit(FLIT_SINGLE, 3, 1));
        check("l_east_dir", 64'(direction_out[4*5 +: 5]), 64'(5'b00001));
        check("l_east_err", 64'(rc_err[4]), 64'(0));
        check("mx3_dir", 64'(direction_out_3[4*5 +: 5]), 64'(5'b10000));
        check("mx3_err", 64'(rc_err_3[4]), 64'(1));

        // Adaptive head: E pressure 5, N pressure 2
        pressure_in = {4'd2, 4'd0, 4'd0, 4'd5};
        send1(CH_E, mk_flit(FLIT_HEAD, 2, 3));
`ifdef RC_ADAPTIVE_EN
        check("adapt_head_dir", 64'(direction_out[4:0]), 64'(5'b01000));
`else
        check("adapt_head_dir", 64'(direction_out[4:0]), 64'(5'b00001));
`endif
        send1(CH_E, mk_flit(FLIT_TAIL, 0, 0));
        check("adapt_tail_err", 64'(rc_err[0]), 64'(0));

        // Tie goes to X, then wormhole holds E despite pressure change
        pressure_in = {4'd3, 4'd0, 4'd0, 4'd3};
        send1(CH_E, mk_flit(FLIT_HEAD, 2, 3));
        check("tie_head_dir", 64'(direction_out[4:0]), 64'(5'b00001));
        pressure_in = {4'd0, 4'd0, 4'd0, 4'd7};
        send1(CH_E, mk_flit(FLIT_BODY, 1, 0));
        check("worm_body_dir", 64'(direction_out[4:0]), 64'(5'b00001));
        send1(CH_E, mk_flit(FLIT_TAIL, 0, 2));
        check("worm_tail_dir", 64'(direction_out[4:0]), 64'(5'b00001));
        check("worm_tail_err", 64'(rc_err[0]), 64'(0));
        send1(CH_E, mk_flit(FLIT_SINGLE, 0, 0));
        check("worm_single_dir", 64'(direction_out[4:0]), 64'(5'b00100));

        // Backpressure on W channel
        fa = mk_flit(FLIT_SINGLE, 0, 1);
        fb = mk_flit(FLIT_SINGLE, 0, 2);
        fc = mk_flit(FLIT_SINGLE, 0, 0);
        rc_ready[1] = 0; in_valid[1] = 1; in_data[1*DS +: DS] = fa;
        step();
        in_data[1*DS +: DS] = fb;
        repeat (3) begin
            step();
            check("bp_in_ready", 64'(in_ready[1]), 64'(0));
            check("bp_data_hold", 64'(data_out[1*DS +: DS]), 64'(fa));
        end
        rc_ready[1] = 1;
        step();
        check("bp_rel_flit1", 64'(data_out[1*DS +: DS]), 64'(fb));
        in_data[1*DS +: DS] = fc;
        step();
        check("bp_rel_flit2", 64'(data_out[1*DS +: DS]), 64'(fc));
        check("bp_rel_valid", 64'(out_valid[1]), 64'(1));
        in_valid = '0;
        step();

        // Body in IDLE, then pulse clears
        send1(CH_S, mk_flit(FLIT_BODY, 2, 2));
        check("idle_body_dir", 64'(direction_out[2*5 +: 5]), 64'(5'b10000));
        check("idle_body_err", 64'(rc_err[2]), 64'(1));
        step();
        check("err_pulse_clear", 64'(rc_err[2]), 64'(0));

        // Reset between head and tail discards the lock
        send1(CH_N, mk_flit(FLIT_HEAD, 2, 3));
        rst_n = 0;
        step();
        rst_n = 1;
        send1(CH_N, mk_flit(FLIT_BODY, 2, 3));
        check("rst_mid_body_err", 64'(rc_err[3]), 64'(1));
        check("rst_mid_body_dir", 64'(direction_out[3*5 +: 5]), 64'(5'b10000));

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst_n       = ($urandom_range(0, 63) != 0);
            in_valid    = NCH'($urandom);
            rc_ready    = NCH'($urandom);
            pressure_in = 16'($urandom);
            for (int c = 0; c < NCH; c++)
                in_data[c*DS +: DS] = mk_flit(2'($urandom_range(0, 3)),
                                              $urandom_range(0, 3), $urandom_range(0, 3));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rc_mesh_adaptive.md
Name: rc_mesh_adaptive

Overview:
Parametrised route-computation stage for one mesh router node; it generalises the fixed per-node RC wrappers to any (X,Y) position and mesh size.
- NUM_CH independent channels, each with a one-flit pipeline register and valid/ready handshake.
- Wormhole route locking: the head flit computes the route; body and tail flits reuse it.
- Minimal adaptive routing driven by neighbour pressure.
- Sits between the input FIFOs and the switch allocator.

Parameters:
- X_COORD, 0, node X position (east is +X).
- Y_COORD, 1, node Y position (north is +Y).
- MESH_X, 4, mesh columns.
- MESH_Y, 4, mesh rows.
- CW, 2, coordinate field width in bits.
- DATASIZE, 40, flit width.
- WIDTH, 3, pressure is WIDTH+1 bits (FIFO occupancy 0..DEPTH).
- NUM_CH, 5, input channels; index 0..4 = E, W, S, N, L.

Ports:
- rc_clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_data  in  NUM_CH*DATASIZE  flits; channel c at [c*DATASIZE +: DATASIZE]
- in_valid  in  NUM_CH  flit valid per channel
- in_ready  out  NUM_CH  stage can accept a flit on the channel
- pressure_in  in  4*(WIDTH+1)  neighbour occupancy; slots 0..3 = E, W, S, N
- data_out  out  NUM_CH*DATASIZE  registered flits
- direction_out  out  NUM_CH*5  one-hot route; bit0 = E, bit1 = W, bit2 = S, bit3 = N, bit4 = L
- out_valid  out  NUM_CH  output register holds a flit
- rc_ready  in  NUM_CH  downstream (allocator) accepts the flit
- rc_err  out  NUM_CH  one-cycle pulse on a protocol or destination error

Behaviour:
Flit format:
- [DATASIZE-1 -: 2] is the flit type: 10 = head, 00 = body, 01 = tail, 11 = single.
- [2*CW-1:CW] is dest_x; [CW-1:0] is dest_y.

Reset (rst_n = 0 at a rc_clk edge):
- out_valid, data_out, direction_out and rc_err clear to 0.
- All channel FSMs go to IDLE.
- in_ready is combinational, so it reads 1 after reset.

Handshake, per channel:
- in_ready = !out_valid || rc_ready.
- Accept when in_valid && in_ready; the flit appears on data_out/out_valid on the next edge, so latency is 1 cycle.
- If the output is held (out_valid && !rc_ready), data_out and direction_out stay stable.
- Simultaneous accept and drain produces back-to-back throughput with no bubble.
- No combinational path from in_valid to out_valid.

Route function for head and single flits:
- dx: E if dest_x > X_COORD, W if dest_x < X_COORD, otherwise none.
- dy: N if dest_y > Y_COORD, S if dest_y < Y_COORD, otherwise none.
- Neither productive: direction is L.
- Exactly one productive: take it.
- Both productive: adaptive choice between the two, see Optional Feature.
- Illegal destination (dest_x >= MESH_X or dest_y >= MESH_Y): direction L, and rc_err pulses in the output cycle.

Per-channel FSM:
- IDLE:
  - Head accepted: compute the route, latch it into lock_dir, go to LOCKED.
  - Single accepted: compute the route, stay IDLE.
  - Body or tail accepted: direction L, rc_err pulses, stay IDLE.
- LOCKED:
  - Body accepted: use lock_dir.
  - Tail accepted: use lock_dir, return to IDLE on that acceptance.
  - Head or single accepted: recompute the route, rc_err pulses; a head re-locks, a single returns to IDLE.
- Pressure affects head and single flits only, never a locked packet.
- Reset mid-packet discards the lock and any held flit.

Comparison rules:
- Pressure is compared unsigned at full WIDTH+1 width.
- Slots for directions that point off the mesh edge are ignored; those directions are never productive.

Optional Feature:
Macro RC_ADAPTIVE_EN.
- Defined: when both dx and dy are productive, choose the one with the strictly lower pressure; a tie goes to dx (X first).
- Undefined: deterministic XY routing; dx always wins, and pressure_in is unused but the port remains.

Decomposition:
Shared package rc_pkg holds:
- flit-type constants: FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE;
- one-hot direction constants: DIR_E, DIR_W, DIR_S, DIR_N, DIR_L;
- the channel index constants.

Sub-module rc_channel is instantiated NUM_CH times via generate. It holds the pipeline register, the FSM, lock_dir and the route function. The top module only slices the buses.

Test Plan (X=0, Y=1, 4x4 mesh, CW=2):
- Reset: hold rst_n=0 for 2 cycles with in_valid=all ones -> out_valid=0, direction_out=0, rc_err=0, in_ready=all ones.
- L channel, single flit, dest (0,1) -> next cycle out_valid[4]=1, direction_out[4]=5'b10000; dest (3,1) -> 5'b00001 (E).
- E channel, head to dest (2,3) with E pressure 5 and N pressure 2 -> N (5'b01000) when RC_ADAPTIVE_EN is defined, E (5'b00001) when undefined; pressures 3 and 3 -> E.
- Wormhole: head to (2,3) routed E, then change pressures; body and tail still report E; a following single to (0,0) routes S.
- Backpressure: hold rc_ready=0 for 3 cycles -> in_ready=0 and data_out stable; release with in_valid held -> 2 flits in 2 cycles, no bubble.
- Errors:
  - Body flit in IDLE -> L plus a 1-cycle rc_err.
  - dest_x=3 with MESH_X=3 -> L plus rc_err.
  - Reset asserted between head and tail -> the next body flit is flagged rc_err.
